onchip_mem_test_master: RTL and testbench

- Avalon-MM initiator (master) that drives the on-chip memory slave port.
- Fills a word range with a seeded incrementing pattern, reads it back, compares each word, and reports the error count and the first failing address.
- Used as a built-in self-test and bring-up engine. It sits beside the Nios path on the same 32-bit, 17-bit word-address slave interface.

---
 rtl/onchip_mem_test_master.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_onchip_mem_test_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM self-test initiator: fills a word range with seed+i, reads it back and counts mismatches.
// Define ONCHIP_MEM_TEST_INV_PASS_EN to add a second pass using the inverted pattern ~(seed+i).
module onchip_mem_test_master #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_count,
    input  logic [DATA_W-1:0]   cmd_seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);
    localparam int RL = READ_LATENCY;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W:0] IDX_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ERR_MAX  = {(ADDR_W+1){1'b1}};

    function automatic logic [DATA_W-1:0] pattern_f(input logic [DATA_W-1:0] seed,
                                                    input logic [ADDR_W:0]   idx,
                                                    input logic              inv);
        logic [DATA_W-1:0] p;
        p = seed + DATA_W'(idx);
        if (inv) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    function automatic logic [ADDR_W-1:0] addr_f(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W:0]   idx);
        return base + idx[ADDR_W-1:0];
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RL-1:0]     pv_q, pv_d;
    logic [ADDR_W-1:0] pa_q [RL];
    logic [ADDR_W-1:0] pa_d [RL];
    logic [DATA_W-1:0] pe_q [RL];
    logic [DATA_W-1:0] pe_d [RL];
    logic              inv_s;
    logic              drain_empty_s;
    logic              last_s;
    logic [ADDR_W:0]   idx_nx_s;

`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
    logic inv_q, inv_d;
    assign inv_s = inv_q;
`else
    assign inv_s = 1'b0;
`endif

    assign idx_nx_s = idx_q + IDX_ONE;
    assign last_s   = (idx_q == (count_q - IDX_ONE));

    // Next-state, request generation, readback pipeline and compare
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        seed_d  = seed_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
        inv_d   = inv_q;
`endif
        pv_d[0] = 1'b0;
        pa_d[0] = pa_q[0];
        pe_d[0] = pe_q[0];
        for (int j = 1; j < RL; j++) begin
            pv_d[j] = pv_q[j-1];
            pa_d[j] = pa_q[j-1];
            pe_d[j] = pe_q[j-1];
        end
        // Only the oldest slot may still be occupied when leaving DRAIN; it is compared on that edge.
        drain_empty_s = 1'b1;
        for (int j = 0; j < RL - 1; j++) begin
            if (pv_q[j]) begin
                drain_empty_s = 1'b0;
            end else begin
                drain_empty_s = drain_empty_s;
            end
        end

        if (pv_q[RL-1] && (avm_readdata != pe_q[RL-1])) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + IDX_ONE;
            end else begin
                err_d = err_q;
            end
            if (err_q == IDX_ZERO) begin
                ferr_d = pa_q[RL-1];
            end else begin
                ferr_d = ferr_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    base_d  = cmd_base;
                    count_d = cmd_count;
                    seed_d  = cmd_seed;
                    idx_d   = IDX_ZERO;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = IDX_ZERO;
                    ferr_d  = {ADDR_W{1'b0}};
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
                    inv_d   = 1'b0;
`endif
                    if (cmd_count == IDX_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WRITE;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = cmd_base;
                        wdata_d = cmd_seed;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    if (last_s) begin
                        state_d = S_READ;
                        idx_d   = IDX_ZERO;
                        wr_d    = 1'b0;
                        addr_d  = base_q;
                    end else begin
                        idx_d   = idx_nx_s;
                        addr_d  = addr_f(base_q, idx_nx_s);
                        wdata_d = pattern_f(seed_q, idx_nx_s, inv_s);
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                if (!avm_waitrequest) begin
                    pv_d[0] = 1'b1;
                    pa_d[0] = addr_q;
                    pe_d[0] = pattern_f(seed_q, idx_q, inv_s);
                    if (last_s) begin
                        state_d = S_DRAIN;
                        idx_d   = IDX_ZERO;
                        cs_d    = 1'b0;
                    end else begin
                        idx_d   = idx_nx_s;
                        addr_d  = addr_f(base_q, idx_nx_s);
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (drain_empty_s) begin
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
                    if (!inv_q) begin
                        state_d = S_WRITE;
                        inv_d   = 1'b1;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = base_q;
                        wdata_d = pattern_f(seed_q, IDX_ZERO, 1'b1);
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == IDX_ZERO);
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cs_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and registered output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= {ADDR_W{1'b0}};
            count_q <= IDX_ZERO;
            seed_q  <= {DATA_W{1'b0}};
            idx_q   <= IDX_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= IDX_ZERO;
            ferr_q  <= {ADDR_W{1'b0}};
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            pv_q    <= {RL{1'b0}};
            for (int j = 0; j < RL; j++) begin
                pa_q[j] <= {ADDR_W{1'b0}};
                pe_q[j] <= {DATA_W{1'b0}};
            end
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
            pe_q    <= pe_d;
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = {(DATA_W/8){1'b1}};
    assign avm_chipselect = cs_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Bench for onchip_mem_test_master: table of directed runs on a READ_LATENCY=1 instance,
// plus hand sequences (done/start overlap, mid-run reset, random stalls on a READ_LATENCY=2 instance).
module tb_onchip_mem_test_master;
    localparam int AW = 17;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   count;
        logic [DW-1:0] seed;
        logic          stuck_en;
        logic [AW-1:0] stuck_addr;
        logic          exp_pass;
        logic [AW:0]   exp_err;
        logic [AW-1:0] exp_ferr;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start0 = 1'b0;
    logic          start1 = 1'b0;
    logic [AW-1:0] cmd_base = 17'h0;
    logic [AW:0]   cmd_count = 18'h0;
    logic [DW-1:0] cmd_seed = 32'h0;
    logic          wait0 = 1'b0;
    logic          wait1 = 1'b0;
    logic          stuck_en = 1'b0;
    logic [AW-1:0] stuck_addr = 17'h0;

    logic          busy0, done0, pass0, cs0, wr0, ck0;
    logic [AW:0]   err0;
    logic [AW-1:0] ferr0, addr0;
    logic [3:0]    be0;
    logic [DW-1:0] wd0;
    logic [DW-1:0] rd0 = 32'h0;
    logic          busy1, done1, pass1, cs1, wr1, ck1;
    logic [AW:0]   err1;
    logic [AW-1:0] ferr1, addr1;
    logic [3:0]    be1;
    logic [DW-1:0] wd1;
    logic [DW-1:0] rd1_a = 32'h0;
    logic [DW-1:0] rd1_b = 32'h0;

    logic [DW-1:0] mem0 [0:131071];
    logic [DW-1:0] mem1 [0:131071];
    int acc0 = 0;
    int acc1 = 0;
    int checks = 0;
    int errors = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    onchip_mem_test_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .start(start0), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .cmd_seed(cmd_seed), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_addr(ferr0), .avm_address(addr0), .avm_byteenable(be0), .avm_chipselect(cs0),
        .avm_write(wr0), .avm_writedata(wd0), .avm_clken(ck0), .avm_readdata(rd0),
        .avm_waitrequest(wait0));

    onchip_mem_test_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u1 (
        .clk(clk), .reset(reset), .start(start1), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .cmd_seed(cmd_seed), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_addr(ferr1), .avm_address(addr1), .avm_byteenable(be1), .avm_chipselect(cs1),
        .avm_write(wr1), .avm_writedata(wd1), .avm_clken(ck1), .avm_readdata(rd1_b),
        .avm_waitrequest(wait1));

    // Ideal memory, one-cycle read, optional bit-0 stuck-at-1 fault
    always @(posedge clk) begin
        if (cs0 && !wait0) begin
            acc0 <= acc0 + 1;
            if (wr0) mem0[addr0] <= wd0;
            else rd0 <= mem0[addr0] | ((stuck_en && (addr0 == stuck_addr)) ? 32'h1 : 32'h0);
        end
    end

    // Ideal memory, two-cycle read
    always @(posedge clk) begin
        rd1_b <= rd1_a;
        if (cs1 && !wait1) begin
            acc1 <= acc1 + 1;
            if (wr1) mem1[addr1] <= wd1;
            else rd1_a <= mem1[addr1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_cyc(input int c, input int rl);
        if (c == 0) return 2;
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
        return 4 * c + 2 * rl + 2;
`else
        return 2 * c + rl + 2;
`endif
    endfunction

    function automatic int exp_acc(input int c);
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
        return 4 * c;
`else
        return 2 * c;
`endif
    endfunction

    function automatic int mem_bad(input int sel, input logic [AW-1:0] b, input int c,
                                   input logic [DW-1:0] s);
        int bad;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        bad = 0;
        for (int i = 0; i < c; i++) begin
            a = b + AW'(i);
            e = s + DW'(i);
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
            e = ~e;
`endif
            if (sel == 0) begin
                if (mem0[a] !== e) bad++;
            end else begin
                if (mem1[a] !== e) bad++;
            end
        end
        return bad;
    endfunction

    task automatic wait_done0(output int n);
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (done0) break;
        end
    endtask

    task automatic run0(input vec_t v, input string tag);
        int n;
        int a_before;
        cmd_base   = v.base;
        cmd_count  = v.count;
        cmd_seed   = v.seed;
        stuck_en   = v.stuck_en;
        stuck_addr = v.stuck_addr;
        a_before   = acc0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_done0(n);
        chk({tag, " done_cycle"}, n, exp_cyc(int'(v.count), 1));
        chk({tag, " pass"}, pass0, v.exp_pass);
        chk({tag, " err_count"}, err0, v.exp_err);
        chk({tag, " first_err_addr"}, ferr0, v.exp_ferr);
        chk({tag, " busy_at_done"}, busy0, 1'b0);
        chk({tag, " accesses"}, acc0 - a_before, exp_acc(int'(v.count)));
        chk({tag, " mem_bad_words"}, mem_bad(0, v.base, int'(v.count), v.seed), 0);
    endtask

    initial begin
        int n;
        int ndone;
        int a1;

        vecs[0] = '{17'h00100, 18'd8, 32'h1000_0000, 1'b0, 17'h0, 1'b1, 18'd0, 17'h0};
`ifdef ONCHIP_MEM_TEST_INV_PASS_EN
        vecs[1] = '{17'h00100, 18'd8, 32'h1000_0000, 1'b1, 17'h00103, 1'b0, 18'd1, 17'h00103};
`else
        vecs[1] = '{17'h00100, 18'd8, 32'h1000_0000, 1'b1, 17'h00103, 1'b1, 18'd0, 17'h0};
`endif
        vecs[2] = '{17'h00100, 18'd8, 32'h1000_0000, 1'b1, 17'h00104, 1'b0, 18'd1, 17'h00104};
        vecs[3] = '{17'h00100, 18'd0, 32'h1000_0000, 1'b0, 17'h0, 1'b1, 18'd0, 17'h0};
        vecs[4] = '{17'h1FFFE, 18'd4, 32'hFFFF_FFFE, 1'b0, 17'h0, 1'b1, 18'd0, 17'h0};
        vecs[5] = '{17'h01234, 18'd1, 32'h0000_0000, 1'b1, 17'h01234, 1'b0, 18'd1, 17'h01234};

        repeat (3) @(negedge clk);
        chk("reset flags", {busy0, done0, pass0, cs0, wr0, ck0}, 6'b000001);
        chk("reset byteenable", be0, 4'hF);
        chk("reset err/addr", {err0, ferr0, addr0}, 52'h0);
        chk("reset writedata", wd0, 32'h0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run0(vecs[k], $sformatf("v%0d", k));

        // done pulse vs start overlap
        run0(vecs[0], "v0b");
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        chk("start_on_done ignored", busy0, 1'b0);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        chk("start_after_done accepted", busy0, 1'b1);
        wait_done0(n);
        chk("start_after_done pass", pass0, 1'b1);

        // reset in the middle of the read phase
        cmd_base = 17'h00100; cmd_count = 18'd8; cmd_seed = 32'h1000_0000; stuck_en = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_reset in READ", {busy0, cs0, wr0}, 3'b110);
        reset = 1'b1;
        #1;
        chk("async reset flags", {busy0, done0, pass0, cs0, wr0, ck0}, 6'b000001);
        chk("async reset addr/data", {addr0, wd0, err0}, 67'h0);
        chk("async reset byteenable", be0, 4'hF);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("no done after reset", ndone, 0);
        run0(vecs[0], "post_reset");

        // random stalls, READ_LATENCY=2, with a start while busy
        cmd_base = 17'h02000; cmd_count = 18'd64; cmd_seed = 32'hA5A5_0000;
        a1 = acc1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            wait1 = 1'($urandom_range(0, 1));
            if (n == 10) begin
                chk("busy at second start", busy1, 1'b1);
                cmd_base = 17'h03000; cmd_count = 18'd5; cmd_seed = 32'h0;
                start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            if (done1) break;
        end
        wait1 = 1'b0;
        chk("rand done within bound", n < 3000, 1'b1);
        chk("rand pass", pass1, 1'b1);
        chk("rand err_count", err1, 18'd0);
        chk("rand accesses", acc1 - a1, exp_acc(64));
        chk("rand mem_bad_words", mem_bad(1, 17'h02000, 64, 32'hA5A5_0000), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
